// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum bin store reader and renderer.
package spectrum_pkg;

  localparam int NUM_BINS_DEF = 40;
  localparam int BIN_W        = 8;
  localparam int LEVEL_W_DEF  = 5;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } reader_state_t;

  typedef struct packed {
    logic [BIN_W-1:0]       index;
    logic [LEVEL_W_DEF-1:0] level;
    logic [BIN_W-1:0]       peak;
  } bin_record_t;

  // Peak-hold with linear fall: a fresh sample at or above the held peak
  // replaces it; otherwise the held peak falls by decay and floors at 0.
  function automatic logic [BIN_W-1:0] peak_next(
    input logic [BIN_W-1:0] sample,
    input logic [BIN_W-1:0] held,
    input logic [BIN_W-1:0] decay
  );
    logic [BIN_W:0] diff;
    diff = {1'b0, held} - {1'b0, decay};
    if (sample >= held) begin
      return sample;
    end else if (diff[BIN_W]) begin
      return '0;
    end else begin
      return diff[BIN_W-1:0];
    end
  endfunction

endpackage

// File: rtl/bin_peak_mem.sv
// Held-peak storage: one byte per bin, combinational read, synchronous write,
// whole array cleared by reset.
module bin_peak_mem #(
  parameter int DEPTH = 40,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Clear every held peak on reset, otherwise take single writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/spectrum_bin_reader.sv
// Sweeps all bins of the filter store once per frame, applies peak-hold
// and streams (index, level, peak) records over valid/ready.
//
// state | meaning
// IDLE  | waiting for a frame request
// READ  | sample rd_data for bin idx, update its held peak
// SEND  | record for bin idx offered downstream until accepted
// DONE  | one-cycle frame_done after the last record is accepted
module spectrum_bin_reader
  import spectrum_pkg::*;
#(
  parameter int NUM_BINS   = NUM_BINS_DEF,
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int PEAK_DECAY = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [7:0]         rd_addr,
  input  logic [7:0]         rd_data,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic [7:0]         bin_index,
  output logic [LEVEL_W-1:0] bin_level,
  output logic [7:0]         bin_peak,
  output logic               busy,
  output logic               frame_done
);

  localparam int AW = $clog2(NUM_BINS);

  reader_state_t state, state_nx;
  logic [7:0]    idx;
  logic [7:0]    data_q;
  logic [7:0]    peak_q;
  logic [7:0]    peak_held;
  logic [7:0]    new_peak;
  logic          peak_we;
  logic          last_bin;
  logic          handshake;

  assign last_bin  = (idx == 8'(NUM_BINS - 1));
  assign bin_valid = (state == SEND);
  assign handshake = bin_valid && bin_ready;
  assign new_peak  = peak_next(rd_data, peak_held, 8'(PEAK_DECAY));

  bin_peak_mem #(
    .DEPTH (NUM_BINS),
    .AW    (AW)
  ) u_peak_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (peak_we),
    .waddr (idx[AW-1:0]),
    .wdata (new_peak),
    .raddr (idx[AW-1:0]),
    .rdata (peak_held)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; the peak write happens only in READ so each bin is
  // updated exactly once per frame.
  always_comb begin
    state_nx = state;
    peak_we  = 1'b0;
    case (state)
      IDLE: if (start) state_nx = READ;
      READ: begin
        peak_we  = 1'b1;
        state_nx = SEND;
      end
      SEND: if (handshake) state_nx = last_bin ? DONE : READ;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bin counter and record registers; record fields only change in READ,
  // so they are stable for the whole SEND stretch.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      data_q <= '0;
      peak_q <= '0;
    end else begin
      case (state)
        IDLE: if (start) idx <= '0;
        READ: begin
          data_q <= rd_data;
          peak_q <= new_peak;
        end
        SEND: if (handshake && !last_bin) idx <= idx + 8'd1;
        default: ;
      endcase
    end
  end

  assign rd_addr    = idx;
  assign bin_index  = idx;
  assign bin_level  = data_q[7 -: LEVEL_W];
  assign bin_peak   = peak_q;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

endmodule

// File: doc/spectrum_bin_reader.md
# spectrum_bin_reader

Reader side of the per-bin exponential-filter store. On each frame request it sweeps all spectrum bins in address order and reads each filtered magnitude through the store's combinational read port. It applies a per-bin peak-hold with linear fall and streams (index, level, peak) records to the LED-strip renderer over a valid/ready handshake. It sits between the bin filter store and the strip pixel generator.

## Interface
- NUM_BINS, 40, number of bins swept per frame (addresses 0..NUM_BINS-1)
- LEVEL_W, 5, width of the quantised bar level
- PEAK_DECAY, 1, amount subtracted from a held peak per frame when not refreshed
- clk  in  1  system clock
- rst  in  1  reset; synchronous and active-high
- start  in  1  frame request pulse; sampled only in IDLE
- rd_addr  out  8  bin address to the filter store
- rd_data  in  8  filtered magnitude at rd_addr; combinational, valid in the same cycle
- bin_valid  out  1  output record valid
- bin_ready  in  1  downstream accepts the record
- bin_index  out  8  bin number of the current record
- bin_level  out  LEVEL_W  rd_data[7:8-LEVEL_W] captured for this bin
- bin_peak  out  8  updated held peak for this bin
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the last record is accepted

## Operation
- FSM states: IDLE, READ, SEND, DONE.
- IDLE, start=1: idx<=0, go to READ. start=0: stay.
- READ: rd_addr=idx. Capture rd_data into data_q. Compute new_peak:
  - if rd_data >= peak[idx]: new_peak = rd_data;
  - else: new_peak = peak[idx] - PEAK_DECAY, saturating at 0.
  - Write new_peak to peak[idx] and to peak_q. Go to SEND.
- SEND: bin_valid=1. bin_index=idx, bin_level=data_q[7:8-LEVEL_W], bin_peak=peak_q. All are held stable until bin_valid && bin_ready.
  - On handshake with idx==NUM_BINS-1: go to DONE.
  - On handshake otherwise: idx<=idx+1, go to READ.
- DONE: frame_done=1 for exactly one cycle, then go to IDLE.
- start outside IDLE is ignored. It is not queued.
- Each peak[idx] is updated exactly once per frame, in its READ cycle.
- rd_addr equals idx in every state. rd_data is only sampled in READ.
- Reset values: state IDLE, idx 0, all peak[] 0, rd_addr 0, bin_valid 0, bin_index 0, bin_level 0, bin_peak 0, busy 0, frame_done 0.
- Reset mid-frame: the sweep is abandoned with no frame_done. Peaks are cleared. The first record after reset comes from a new start.
- Widths: the peak subtraction is done in 9 bits; a negative result clamps to 0. bin_index zero-extends idx.

## Timing
- start sampled high at edge 0 gives READ in cycle 1 and bin_valid high from cycle 2.
- Each bin costs 1 READ cycle plus at least 1 SEND cycle. The SEND cycle stretches while bin_ready=0.
- With bin_ready tied high, one frame lasts 2*NUM_BINS+1 cycles after start: bin 39 is in SEND in cycle 80, frame_done in cycle 81, IDLE in cycle 82.
- Back-to-back frames: start may be asserted in the first IDLE cycle after DONE.
- bin_valid never drops without a handshake, except on rst.

## Structure
- Shared package spectrum_pkg holds:
  - NUM_BINS_DEF=40, BIN_W=8;
  - the reader state enum (IDLE, READ, SEND, DONE);
  - the bin record typedef (index, level, peak) used by the renderer.
- One natural sub-module, bin_peak_mem: NUM_BINS x 8 register array with a combinational read, a synchronous write port and a synchronous clear on rst.
- The FSM, address counter and output registers stay in spectrum_bin_reader.

## Test plan
- Reset, then start with the store model returning rd_data=addr*6 and bin_ready=1:
  - 40 records, index 0..39, bin_level=(addr*6)>>3, bin_peak=addr*6;
  - frame_done in cycle 81.
- Frame 1 with all bins 200, then frame 2 with all bins 50: frame 2 records give bin_peak=199 and bin_level=6.
- Peak floor: bin 0 at 1 in frame 1, then 0 in frames 2 and 3. bin_peak is 0 in frame 2 and stays 0 in frame 3, with no underflow to 255.
- Backpressure: bin_ready low for 5 cycles while bin 7 is in SEND. All record fields stay stable, rd_addr stays 7, no record is skipped, and frame_done is delayed by 5 cycles.
- start pulsed during a frame is ignored. rst asserted while bin 20 is pending:
  - all outputs 0 the next cycle, no frame_done;
  - after a new start, bin_peak equals the fresh rd_data.
